// File: rtl/addac_n.sv
// Registered WIDTH-bit adder/subtractor with accumulator feedback, carry chaining,
// optional unsigned saturation and a sticky overflow flag. One op per cycle, latency 1.
module addac_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  input  logic             acc,
  input  logic             cchain,
  input  logic             sat,
  input  logic             clr,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  localparam logic [1:0] SEL_ADD_A = 2'b00;
  localparam logic [1:0] SEL_ADD_B = 2'b01;
  localparam logic [1:0] SEL_SUB_A = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  logic [WIDTH-1:0] y_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             out_valid_reg;

  logic [WIDTH-1:0] base_val;
  logic [WIDTH-1:0] addend;
  logic             is_sub;
  logic             cin;
  logic [WIDTH:0]   sum_full;
  logic             carry_out;
  logic             ovf_event;
  logic [WIDTH-1:0] y_next;

  assign is_sub = (sel == SEL_SUB_A);

  // Per-bit operand steering: load-sum replaces the accumulator base with b.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_operands
    always_comb begin
      base_val[gi] = 1'b0;
      addend[gi]   = 1'b0;
      unique case (sel)
        SEL_ADD_A: begin
          base_val[gi] = acc & y_reg[gi];
          addend[gi]   = a[gi];
        end
        SEL_ADD_B: begin
          base_val[gi] = acc & y_reg[gi];
          addend[gi]   = b[gi];
        end
        SEL_SUB_A: begin
          base_val[gi] = acc & y_reg[gi];
          addend[gi]   = ~a[gi];
        end
        SEL_LOAD: begin
          base_val[gi] = b[gi];
          addend[gi]   = a[gi];
        end
        default: begin
          base_val[gi] = 1'b0;
          addend[gi]   = 1'b0;
        end
      endcase
    end
  end

  // Unchained subtract injects the +1 of two's complement; chained ops reuse last carry.
  assign cin       = cchain ? cout_reg : is_sub;
  assign sum_full  = {1'b0, base_val} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
  assign carry_out = sum_full[WIDTH];
  assign ovf_event = is_sub ? ~carry_out : carry_out;

  always_comb begin
    y_next = sum_full[WIDTH-1:0];
    if (sat && ovf_event) begin
      y_next = {WIDTH{~is_sub}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_reg         <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (clr) begin
      y_reg         <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (in_valid) begin
      y_reg         <= y_next;
      cout_reg      <= carry_out;
      ovf_reg       <= ovf_reg | ovf_event;
      out_valid_reg <= 1'b1;
    end else begin
      out_valid_reg <= 1'b0;
    end
  end

  assign y         = y_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;
  assign out_valid = out_valid_reg;

endmodule
